// File: rtl/vx_tcache_arb_pkg.sv
// rtl/vx_tcache_arb_pkg.sv - shared types and helpers for the tcache request arbiter
package vx_tcache_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    localparam int TAG_PACK_W = 64;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Requester index sits in the LSBs so the response path can peel it off first.
    function automatic logic [TAG_PACK_W-1:0] pack_tag(
        input logic [TAG_PACK_W-1:0] tag,
        input logic [TAG_PACK_W-1:0] idx,
        input int                    idx_bits
    );
        return (tag << idx_bits) | idx;
    endfunction

endpackage

// File: rtl/vx_rr_picker.sv
// rtl/vx_rr_picker.sv - combinational priority search starting at a rotating pointer
module vx_rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    always_comb begin
        int j;
        onehot = '0;
        idx    = ptr;
        j      = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (onehot == '0 && req[j]) begin
                onehot[j] = 1'b1;
                idx       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/vx_tcache_req_arb.sv
// rtl/vx_tcache_req_arb.sv - round-robin arbiter of texture-unit batches onto the tcache request port
module vx_tcache_req_arb
    import vx_tcache_arb_pkg::*;
#(
    parameter int NUM_INPUTS    = 4,
    parameter int NUM_REQS      = 4,
    parameter int WORD_SIZE     = 4,
    parameter int ADDR_WIDTH    = 30,
    parameter int TAG_IN_WIDTH  = 8,
    parameter int TAG_OUT_WIDTH = TAG_IN_WIDTH + idx_w(NUM_INPUTS)
) (
    input  logic                                                    clk,
    input  logic                                                    reset_n,
    input  logic [NUM_INPUTS-1:0]                                   in_valid,
    input  logic [NUM_INPUTS-1:0][NUM_REQS-1:0]                     in_mask,
    input  logic [NUM_INPUTS-1:0]                                   in_rw,
    input  logic [NUM_INPUTS-1:0][NUM_REQS-1:0][WORD_SIZE-1:0]      in_byteen,
    input  logic [NUM_INPUTS-1:0][NUM_REQS-1:0][ADDR_WIDTH-1:0]     in_addr,
    input  logic [NUM_INPUTS-1:0][NUM_REQS-1:0][8*WORD_SIZE-1:0]    in_data,
    input  logic [NUM_INPUTS-1:0][TAG_IN_WIDTH-1:0]                 in_tag,
    output logic [NUM_INPUTS-1:0]                                   in_ready,
    output logic [NUM_REQS-1:0]                                     out_valid,
    output logic [NUM_REQS-1:0]                                     out_rw,
    output logic [NUM_REQS-1:0][WORD_SIZE-1:0]                      out_byteen,
    output logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]                     out_addr,
    output logic [NUM_REQS-1:0][8*WORD_SIZE-1:0]                    out_data,
    output logic [NUM_REQS-1:0][TAG_OUT_WIDTH-1:0]                  out_tag,
    input  logic [NUM_REQS-1:0]                                     out_ready,
    output logic                                                    busy,
    output logic [idx_w(NUM_INPUTS)-1:0]                            grant_idx
);

    localparam int IDX_W = idx_w(NUM_INPUTS);

    arb_state_t            state;
    logic [IDX_W-1:0]      lock_idx;
    logic [IDX_W-1:0]      rr_ptr;
    logic [NUM_REQS-1:0]   sent;

    logic [NUM_INPUTS-1:0] pick_onehot;
    logic [IDX_W-1:0]      pick_idx;
    logic [IDX_W-1:0]      win;
    logic                  win_valid;
    logic [NUM_REQS-1:0]   win_mask;
    logic [NUM_REQS-1:0]   lane_valid;
    logic [NUM_REQS-1:0]   fire;
    logic                  done;

    vx_rr_picker #(
        .N  (NUM_INPUTS),
        .IW (IDX_W)
    ) u_picker (
        .req    (in_valid),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    always_comb begin
        win        = (state == ST_LOCKED) ? lock_idx : pick_idx;
        win_valid  = (state == ST_LOCKED) ? in_valid[lock_idx] : (|pick_onehot);
        win_mask   = in_mask[win];
        lane_valid = win_valid ? (win_mask & ~sent) : '0;
        fire       = lane_valid & out_ready;
        done       = win_valid && ((sent | fire) == win_mask);
    end

    // Handshake outputs are forced quiet while reset is held, even though they are combinational.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            in_ready[i] = reset_n & done & (win == IDX_W'(i));
        end
    end

    assign out_valid = reset_n ? lane_valid : '0;
    assign grant_idx = reset_n ? win : '0;
    assign busy      = (state == ST_LOCKED);

    always_comb begin
        for (int l = 0; l < NUM_REQS; l++) begin
            out_rw[l]     = in_rw[win];
            out_byteen[l] = in_byteen[win][l];
            out_addr[l]   = in_addr[win][l];
            out_data[l]   = in_data[win][l];
            out_tag[l]    = TAG_OUT_WIDTH'(pack_tag(TAG_PACK_W'(in_tag[win]), TAG_PACK_W'(win), IDX_W));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            lock_idx <= '0;
            rr_ptr   <= '0;
            sent     <= '0;
        end else begin
            if (state == ST_LOCKED) begin
                assert (in_valid[lock_idx]) else $error("locked requester dropped in_valid");
            end
            if (done) begin
                sent   <= '0;
                state  <= ST_IDLE;
                rr_ptr <= (win == IDX_W'(NUM_INPUTS - 1)) ? '0 : win + 1'b1;
            end else if (win_valid) begin
                sent     <= sent | fire;
                state    <= ST_LOCKED;
                lock_idx <= win;
            end
        end
    end

endmodule

// File: tb/tb_vx_tcache_req_arb.sv
// tb/tb_vx_tcache_req_arb.sv - self-checking bench for vx_tcache_req_arb
module tb_vx_tcache_req_arb;

    localparam int NI  = 4;
    localparam int NR  = 4;
    localparam int WS  = 4;
    localparam int AW  = 30;
    localparam int TW  = 8;
    localparam int IW  = 2;
    localparam int TOW = TW + IW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]                  in_valid;
    logic [NI-1:0][NR-1:0]          in_mask;
    logic [NI-1:0]                  in_rw;
    logic [NI-1:0][NR-1:0][WS-1:0]  in_byteen;
    logic [NI-1:0][NR-1:0][AW-1:0]  in_addr;
    logic [NI-1:0][NR-1:0][8*WS-1:0] in_data;
    logic [NI-1:0][TW-1:0]          in_tag;
    logic [NI-1:0]                  in_ready;
    logic [NR-1:0]                  out_valid;
    logic [NR-1:0]                  out_rw;
    logic [NR-1:0][WS-1:0]          out_byteen;
    logic [NR-1:0][AW-1:0]          out_addr;
    logic [NR-1:0][8*WS-1:0]        out_data;
    logic [NR-1:0][TOW-1:0]         out_tag;
    logic [NR-1:0]                  out_ready;
    logic                           busy;
    logic [IW-1:0]                  grant_idx;

    vx_tcache_req_arb #(
        .NUM_INPUTS   (NI),
        .NUM_REQS     (NR),
        .WORD_SIZE    (WS),
        .ADDR_WIDTH   (AW),
        .TAG_IN_WIDTH (TW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_mask    (in_mask),
        .in_rw      (in_rw),
        .in_byteen  (in_byteen),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .in_tag     (in_tag),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_rw     (out_rw),
        .out_byteen (out_byteen),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .out_ready  (out_ready),
        .busy       (busy),
        .grant_idx  (grant_idx)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model: who owns the port, which of its lanes are still outstanding,
    // and where the next round-robin search begins.
    int            m_owner;
    logic [NR-1:0] m_rem;
    int            m_next;
    logic [NR-1:0] e_valid;
    logic [NI-1:0] e_ready;
    int            e_w;
    logic          e_busy;

    task automatic model_reset();
        m_owner = -1;
        m_rem   = '0;
        m_next  = 0;
    endtask

    task automatic model_eval(input logic [NR-1:0] rdy);
        int w;
        logic [NR-1:0] rem;
        e_busy  = (m_owner >= 0);
        w       = m_owner;
        rem     = m_rem;
        e_ready = '0;
        if (w < 0) begin
            for (int i = 0; i < NI; i++) begin
                int k;
                k = (m_next + i) % NI;
                if (w < 0 && in_valid[k]) w = k;
            end
            if (w >= 0) rem = in_mask[w];
        end
        e_w     = w;
        e_valid = (w >= 0) ? rem : '0;
        if (w >= 0 && (rem & ~rdy) == '0) e_ready[w] = 1'b1;
    endtask

    task automatic model_commit(input logic [NR-1:0] rdy);
        logic [NR-1:0] left;
        if (e_w >= 0) begin
            left = e_valid & ~rdy;
            if (left == '0) begin
                m_owner = -1;
                m_rem   = '0;
                m_next  = (e_w + 1) % NI;
            end else begin
                m_owner = e_w;
                m_rem   = left;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_batch(input int i, input logic [NR-1:0] mask);
        in_mask[i] = mask;
        in_rw[i]   = 1'($urandom);
        in_tag[i]  = TW'($urandom);
        for (int l = 0; l < NR; l++) begin
            in_byteen[i][l] = WS'($urandom);
            in_addr[i][l]   = AW'($urandom);
            in_data[i][l]   = $urandom;
        end
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        tick();
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 4'b0101;
        out_ready = 4'hF;
        for (int i = 0; i < NI; i++) fill_batch(i, 4'hF);
        #2;
        for (int c = 0; c < 2; c++) begin
            vectors++; if (out_valid !== 4'h0) begin errors++; $display("FAIL reset_out_valid: got %h expected 0", out_valid); end
            vectors++; if (in_ready !== 4'h0) begin errors++; $display("FAIL reset_in_ready: got %h expected 0", in_ready); end
            vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
            vectors++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", grant_idx); end
            tick();
        end
        in_valid = '0;
        reset_n  = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        apply_reset();
        in_valid  = 4'b0001;
        fill_batch(0, 4'hF);
        fill_batch(1, 4'hF);
        out_ready = 4'hF;
        #3;
        vectors++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL single_in_ready: got %b expected 0001", in_ready); end
        vectors++; if (out_valid !== 4'hF) begin errors++; $display("FAIL single_out_valid: got %h expected f", out_valid); end
        for (int l = 0; l < NR; l++) begin
            vectors++; if (out_tag[l] !== {in_tag[0], 2'd0}) begin errors++; $display("FAIL single_tag%0d: got %h expected %h", l, out_tag[l], {in_tag[0], 2'd0}); end
        end
        tick();
        in_valid = 4'b0011;
        #3;
        vectors++; if (grant_idx !== 2'd1) begin errors++; $display("FAIL single_rr_next: got %0d expected 1", grant_idx); end
        tick();
        in_valid = '0;
    endtask

    task automatic test_partial();
        logic [NR-1:0] rdy_seq [3];
        logic [NR-1:0] vld_seq [3];
        rdy_seq = '{4'h1, 4'h2, 4'h8};
        vld_seq = '{4'hB, 4'hA, 4'h8};
        apply_reset();
        fill_batch(2, 4'hB);
        in_valid = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            out_ready = rdy_seq[c];
            #3;
            vectors++; if (out_valid !== vld_seq[c]) begin errors++; $display("FAIL partial_valid c%0d: got %h expected %h", c, out_valid, vld_seq[c]); end
            vectors++; if (busy !== (c != 0)) begin errors++; $display("FAIL partial_busy c%0d: got %b expected %b", c, busy, c != 0); end
            vectors++; if (in_ready !== ((c == 2) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL partial_ready c%0d: got %b", c, in_ready); end
            vectors++; if (grant_idx !== 2'd2) begin errors++; $display("FAIL partial_grant c%0d: got %0d expected 2", c, grant_idx); end
            tick();
        end
        in_valid = '0;
        #3;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL partial_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < NI; i++) fill_batch(i, 4'hF);
        in_valid  = 4'hF;
        out_ready = 4'hF;
        for (int c = 0; c < 5; c++) begin
            #3;
            vectors++; if (grant_idx !== 2'(c % NI)) begin errors++; $display("FAIL b2b_grant c%0d: got %0d expected %0d", c, grant_idx, c % NI); end
            vectors++; if (in_ready !== 4'(1 << (c % NI))) begin errors++; $display("FAIL b2b_ready c%0d: got %b", c, in_ready); end
            vectors++; if (out_tag[0][IW-1:0] !== 2'(c % NI)) begin errors++; $display("FAIL b2b_tag c%0d: got %0d expected %0d", c, out_tag[0][IW-1:0], c % NI); end
            tick();
        end
        in_valid = '0;
    endtask

    task automatic test_lock();
        int exp_g [3];
        exp_g = '{2, 3, 0};
        apply_reset();
        for (int i = 0; i < NI; i++) fill_batch(i, 4'hF);
        in_valid  = 4'b0001;
        out_ready = 4'hF;
        tick();
        in_valid  = 4'b0010;
        out_ready = 4'h3;
        #3;
        vectors++; if (grant_idx !== 2'd1 || in_ready !== 4'h0) begin errors++; $display("FAIL lock_start: got grant %0d ready %b", grant_idx, in_ready); end
        tick();
        in_valid  = 4'b0011;
        out_ready = 4'h4;
        #3;
        vectors++; if (grant_idx !== 2'd1 || out_valid !== 4'hC || in_ready !== 4'h0) begin errors++; $display("FAIL lock_hold: got grant %0d valid %h ready %b", grant_idx, out_valid, in_ready); end
        tick();
        out_ready = 4'h8;
        #3;
        vectors++; if (grant_idx !== 2'd1 || in_ready !== 4'b0010) begin errors++; $display("FAIL lock_done: got grant %0d ready %b", grant_idx, in_ready); end
        tick();
        in_valid  = 4'b1101;
        out_ready = 4'hF;
        for (int c = 0; c < 3; c++) begin
            #3;
            vectors++; if (grant_idx !== 2'(exp_g[c])) begin errors++; $display("FAIL lock_after c%0d: got %0d expected %0d", c, grant_idx, exp_g[c]); end
            tick();
        end
        in_valid = '0;
    endtask

    task automatic test_empty_mask();
        apply_reset();
        fill_batch(3, 4'h0);
        in_valid  = 4'b1000;
        out_ready = 4'h0;
        #3;
        vectors++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL empty_ready: got %b expected 1000", in_ready); end
        vectors++; if (out_valid !== 4'h0) begin errors++; $display("FAIL empty_valid: got %h expected 0", out_valid); end
        tick();
        in_valid = '0;
        #3;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_batch();
        apply_reset();
        fill_batch(0, 4'hF);
        in_valid  = 4'b0001;
        out_ready = 4'h3;
        tick();
        out_ready = 4'h0;
        #3;
        vectors++; if (busy !== 1'b1 || out_valid !== 4'hC) begin errors++; $display("FAIL mid_locked: got busy %b valid %h", busy, out_valid); end
        reset_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 4'h0 || busy !== 1'b0 || in_ready !== 4'h0 || grant_idx !== 2'd0) begin errors++; $display("FAIL mid_reset: got valid %h busy %b ready %b grant %0d", out_valid, busy, in_ready, grant_idx); end
        tick();
        reset_n = 1'b1;
        #3;
        vectors++; if (out_valid !== 4'hF || busy !== 1'b0) begin errors++; $display("FAIL mid_reissue: got valid %h busy %b expected f 0", out_valid, busy); end
        out_ready = 4'hF;
        #1;
        vectors++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL mid_complete: got %b expected 0001", in_ready); end
        tick();
        in_valid = '0;
    endtask

    task automatic test_random();
        logic [NI-1:0] finished;
        apply_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int i = 0; i < NI; i++) begin
                if (!in_valid[i] && $urandom_range(0, 2) != 0) begin
                    fill_batch(i, ($urandom_range(0, 9) == 0) ? 4'h0 : NR'($urandom));
                    in_valid[i] = 1'b1;
                end
            end
            out_ready = ($urandom_range(0, 3) == 0) ? 4'hF : NR'($urandom);
            #3;
            model_eval(out_ready);
            vectors++; if (out_valid !== e_valid) begin errors++; $display("FAIL rnd_valid cyc%0d: got %h expected %h", cyc, out_valid, e_valid); end
            vectors++; if (in_ready !== e_ready) begin errors++; $display("FAIL rnd_ready cyc%0d: got %b expected %b", cyc, in_ready, e_ready); end
            vectors++; if (busy !== e_busy) begin errors++; $display("FAIL rnd_busy cyc%0d: got %b expected %b", cyc, busy, e_busy); end
            if (e_w >= 0) begin
                vectors++; if (grant_idx !== 2'(e_w)) begin errors++; $display("FAIL rnd_grant cyc%0d: got %0d expected %0d", cyc, grant_idx, e_w); end
                for (int l = 0; l < NR; l++) begin
                    if (e_valid[l]) begin
                        vectors++;
                        if (out_addr[l] !== in_addr[e_w][l] || out_data[l] !== in_data[e_w][l] ||
                            out_byteen[l] !== in_byteen[e_w][l] || out_rw[l] !== in_rw[e_w] ||
                            out_tag[l] !== {in_tag[e_w], 2'(e_w)}) begin
                            errors++;
                            $display("FAIL rnd_payload cyc%0d lane%0d: got addr %h tag %h expected addr %h tag %h",
                                     cyc, l, out_addr[l], out_tag[l], in_addr[e_w][l], {in_tag[e_w], 2'(e_w)});
                        end
                    end
                end
            end
            model_commit(out_ready);
            finished = e_ready;
            tick();
            in_valid = in_valid & ~finished;
        end
        in_valid = '0;
    endtask

    initial begin
        in_valid  = '0;
        in_mask   = '0;
        in_rw     = '0;
        in_byteen = '0;
        in_addr   = '0;
        in_data   = '0;
        in_tag    = '0;
        out_ready = '0;
        model_reset();
        test_reset();
        test_single();
        test_partial();
        test_back_to_back();
        test_lock();
        test_empty_mask();
        test_reset_mid_batch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
